cic3_row_readout: RTL and testbench

Downstream readout stage for the 24-filter CIC3 row. On a capture strobe it snapshots all filter outputs at once, then streams the enabled channels out one 25-bit word per handshake on a valid/ready port, tagging each word with channel index and frame ID. It sits between the filter row outputs and the chip-level readout/serializer. It flags snapshots lost while a frame is still draining.

---
 rtl/cic3_row_readout.sv | 103 ++++++++++
 tb/tb_cic3_row_readout.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic3_row_readout.sv
// Readout stage for the CIC3 filter row: snapshots every channel on capture and
// streams the enabled channels over valid/ready, tagged with channel index and frame ID.
module cic3_row_readout #(
    parameter int NUM_CH = 24,
    parameter int DW     = 25,
    parameter int FID_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CH*DW-1:0] din,
    input  logic                 capture,
    input  logic [NUM_CH-1:0]    chan_en,
    input  logic                 clr_overrun,
    output logic [DW-1:0]        dout,
    output logic [4:0]           dout_idx,
    output logic [FID_W-1:0]     dout_fid,
    output logic                 dout_valid,
    output logic                 dout_last,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [DW-1:0]       snap [NUM_CH];
    logic [NUM_CH-1:0]   mask;
    logic [4:0]          idx;

    logic [NUM_CH-1:0]   mask_above;
    logic [4:0]          next_idx;
    logic [4:0]          first_idx;
    logic                hs;
    logic                final_hs;
    logic                accept;
    logic                drop;

    function automatic logic [4:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] bits_above(input logic [NUM_CH-1:0] v,
                                                     input logic [4:0] pos);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i > int'(pos)) r[i] = v[i];
        end
        return r;
    endfunction

    assign mask_above = bits_above(mask, idx);
    assign next_idx   = lowest_set(mask_above);
    assign first_idx  = lowest_set(chan_en);

    assign dout_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign dout_idx   = idx;
    assign dout_last  = (state == SEND) && !(|mask_above);

    assign hs       = dout_valid && dout_ready;
    assign final_hs = hs && dout_last;
    // A capture can only join the stream when the previous frame finishes this cycle.
    assign accept   = capture && ((state == IDLE) || final_hs);
    assign drop     = capture && (state == SEND) && !final_hs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mask     <= '0;
            idx      <= '0;
            dout     <= '0;
            dout_fid <= '0;
            overrun  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
        end else begin
            if (accept && (|chan_en)) begin
                for (int k = 0; k < NUM_CH; k++) snap[k] <= din[DW*k +: DW];
                mask     <= chan_en;
                idx      <= first_idx;
                dout     <= din[DW*int'(first_idx) +: DW];
                dout_fid <= dout_fid + 1'b1;
                state    <= SEND;
            end else if (final_hs) begin
                state <= IDLE;
            end else if (hs) begin
                // dout is preloaded so the word stays registered while skipping disabled channels.
                idx  <= next_idx;
                dout <= snap[next_idx];
            end

            if (drop) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic3_row_readout.sv
// Directed bench for cic3_row_readout: a scoreboard of expected words is filled at
// capture time and drained by a monitor on every observed handshake.
module tb_cic3_row_readout;

    localparam int NUM_CH = 24;
    localparam int DW     = 25;
    localparam int FID_W  = 8;

    logic                 clk;
    logic                 reset_n;
    logic [NUM_CH*DW-1:0] din;
    logic                 capture;
    logic [NUM_CH-1:0]    chan_en;
    logic                 clr_overrun;
    logic [DW-1:0]        dout;
    logic [4:0]           dout_idx;
    logic [FID_W-1:0]     dout_fid;
    logic                 dout_valid;
    logic                 dout_last;
    logic                 dout_ready;
    logic                 busy;
    logic                 overrun;

    typedef struct {
        logic [DW-1:0]    d;
        logic [4:0]       i;
        logic [FID_W-1:0] f;
        logic             l;
    } exp_t;

    exp_t             exp_q[$];
    logic [FID_W-1:0] exp_fid;
    int               n_cmp = 0;
    int               n_bad = 0;

    cic3_row_readout #(.NUM_CH(NUM_CH), .DW(DW), .FID_W(FID_W)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .capture(capture), .chan_en(chan_en),
        .clr_overrun(clr_overrun), .dout(dout), .dout_idx(dout_idx), .dout_fid(dout_fid),
        .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [NUM_CH-1:0] m, input logic [NUM_CH*DW-1:0] data,
                              input logic [FID_W-1:0] f);
        int   hi;
        exp_t e;
        hi = 0;
        for (int k = 0; k < NUM_CH; k++) if (m[k]) hi = k;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) begin
                e.d = data[DW*k +: DW];
                e.i = 5'(k);
                e.f = f;
                e.l = (k == hi);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_din(input int base, input int step);
        for (int k = 0; k < NUM_CH; k++) din[DW*k +: DW] = DW'(base + k * step);
    endtask

    task automatic fill_din_random();
        for (int k = 0; k < NUM_CH; k++) din[DW*k +: DW] = DW'($urandom);
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((dout_valid || exp_q.size() > 0) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_idle"}, 32'(dout_valid), 0);
    endtask

    task automatic wait_idx(input logic [4:0] target, input string tag);
        int n;
        n = 0;
        while (!(dout_valid && dout_idx == target) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(dout_valid && dout_idx == target), 1);
    endtask

    task automatic count_send(input string tag, input int expected);
        int n;
        n = 0;
        while (dout_valid && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_cycles"}, 32'(n), 32'(expected));
    endtask

    // Monitor: scoreboard pop on handshake plus hold-while-stalled check.
    logic             p_valid = 1'b0;
    logic             p_ready = 1'b0;
    logic [DW-1:0]    p_d;
    logic [4:0]       p_i;
    logic [FID_W-1:0] p_f;
    logic             p_l;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_valid <= 1'b0;
        end else begin
            check("busy_eq_valid", 32'(busy), 32'(dout_valid));
            if (p_valid && !p_ready) begin
                check("hold_valid", 32'(dout_valid), 1);
                check("hold_dout", 32'(dout), 32'(p_d));
                check("hold_idx", 32'(dout_idx), 32'(p_i));
                check("hold_fid", 32'(dout_fid), 32'(p_f));
                check("hold_last", 32'(dout_last), 32'(p_l));
            end
            if (dout_valid && dout_ready) begin
                check("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_dout", 32'(dout), 32'(e.d));
                    check("sb_idx", 32'(dout_idx), 32'(e.i));
                    check("sb_fid", 32'(dout_fid), 32'(e.f));
                    check("sb_last", 32'(dout_last), 32'(e.l));
                end
            end
            p_valid <= dout_valid;
            p_ready <= dout_ready;
            p_d     <= dout;
            p_i     <= dout_idx;
            p_f     <= dout_fid;
            p_l     <= dout_last;
        end
    end

    initial begin
        reset_n     = 1'b0;
        capture     = 1'b0;
        chan_en     = '0;
        clr_overrun = 1'b0;
        dout_ready  = 1'b0;
        din         = '0;
        exp_fid     = '0;
        repeat (2) tick();
        check("rst_dout", 32'(dout), 0);
        check("rst_idx", 32'(dout_idx), 0);
        check("rst_fid", 32'(dout_fid), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_last", 32'(dout_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        tick();

        // Full frame, all channels enabled, ready held high.
        fill_din(32'h100000, 1);
        chan_en    = '1;
        dout_ready = 1'b1;
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        check("f1_latency", 32'(dout_valid), 1);
        check("f1_first_idx", 32'(dout_idx), 0);
        count_send("f1", 24);
        drain("f1");

        // Sparse mask: channels 0, 2, 23.
        fill_din(32'h0A0000, 3);
        chan_en = 24'h800005;
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        count_send("f2", 3);
        drain("f2");

        // Random backpressure; din changes after the snapshot.
        fill_din_random();
        chan_en = '1;
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        fill_din_random();
        chan_en = 24'h000001;
        for (int n = 0; n < 2000 && exp_q.size() > 0; n++) begin
            dout_ready = 1'($urandom_range(0, 1));
            tick();
        end
        dout_ready = 1'b1;
        drain("f3");

        // Dropped capture mid-frame (clear on the same cycle loses), then back-to-back capture.
        fill_din_random();
        chan_en = '1;
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        wait_idx(5'd5, "ovr_w5");
        capture     = 1'b1;
        clr_overrun = 1'b1;
        tick();
        capture     = 1'b0;
        clr_overrun = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        check("ovr_fid_kept", 32'(dout_fid), 32'(exp_fid));
        check("ovr_idx_next", 32'(dout_idx), 6);
        fill_din(32'h055000, 7);
        wait_idx(5'd23, "b2b_last");
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        check("b2b_valid", 32'(dout_valid), 1);
        check("b2b_idx", 32'(dout_idx), 0);
        check("b2b_fid", 32'(dout_fid), 32'(exp_fid));
        check("b2b_overrun", 32'(overrun), 1);
        drain("b2b");
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // Reset asserted mid-frame.
        fill_din_random();
        exp_fid++;
        push_frame(chan_en, din, exp_fid);
        pulse_capture();
        wait_idx(5'd10, "rst_w10");
        reset_n = 1'b0;
        #1;
        check("mrst_dout", 32'(dout), 0);
        check("mrst_idx", 32'(dout_idx), 0);
        check("mrst_fid", 32'(dout_fid), 0);
        check("mrst_valid", 32'(dout_valid), 0);
        check("mrst_last", 32'(dout_last), 0);
        check("mrst_busy", 32'(busy), 0);
        exp_q.delete();
        exp_fid = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Empty mask capture does nothing.
        chan_en = '0;
        pulse_capture();
        for (int n = 0; n < 3; n++) begin
            check("empty_valid", 32'(dout_valid), 0);
            check("empty_fid", 32'(dout_fid), 32'(exp_fid));
            tick();
        end

        // 256 single-word frames back to back: frame ID wraps to 0.
        chan_en = 24'h000008;
        fill_din_random();
        for (int n = 0; n < 256; n++) begin
            exp_fid++;
            push_frame(chan_en, din, exp_fid);
        end
        capture = 1'b1;
        repeat (256) tick();
        capture = 1'b0;
        tick();
        check("wrap_valid", 32'(dout_valid), 0);
        check("wrap_fid", 32'(dout_fid), 0);
        check("wrap_drained", 32'(exp_q.size()), 0);
        check("wrap_overrun", 32'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
